// File: rtl/seg7_pkg.sv
// Glyph codes, segment patterns and the code-to-segment lookup shared by the scan controller.
package seg7_pkg;

    localparam logic [3:0] GLYPH_E     = 4'd10;
    localparam logic [3:0] GLYPH_DASH  = 4'd11;
    localparam logic [3:0] GLYPH_BLANK = 4'd15;

    // Segment order {a,b,c,d,e,f,g}, active high
    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_E    = 7'b1001111;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_e;

    function automatic logic [6:0] glyph_to_seg(input logic [3:0] code);
        case (code)
            4'd0:       return SEG_0;
            4'd1:       return SEG_1;
            4'd2:       return SEG_2;
            4'd3:       return SEG_3;
            4'd4:       return SEG_4;
            4'd5:       return SEG_5;
            4'd6:       return SEG_6;
            4'd7:       return SEG_7;
            4'd8:       return SEG_8;
            4'd9:       return SEG_9;
            GLYPH_E:    return SEG_E;
            GLYPH_DASH: return SEG_DASH;
            default:    return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decode: code + dp -> {a..g,dp}; blank_i forces everything dark, dp included.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    assign seg_o = blank_i ? 8'h00 : {glyph_to_seg(code_i), dp_i};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-frame snapshot, dead-time blanking, leading-zero suppression, dp, blink.
// Outputs registered (one cycle behind counter state); blink logic only when SEG7_BLINK_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int REFRESH_DIV  = 25000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_suppress,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam slot_state_e ST_RST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
        $error("seg7_scan_ctrl: BLANK_CYCLES must lie in 0..REFRESH_DIV-1");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_ctrl: DIGITS must lie in 1..8");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("seg7_scan_ctrl: BLINK_FRAMES must be at least 1");
    end

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                slot_end, frame_end, frame_start;
    logic [4*DIGITS-1:0] snap_dat_q, snap_dat_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                snap_lz_q, snap_lz_d;
    logic                blink_off, lz_off, zero_from_sel;
    logic [3:0]          cur_code;
    logic [7:0]          glyph_seg;
    slot_state_e         state_q, state_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_tick_q;

    assign slot_end    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_end   = slot_end && (sel_q == SEL_W'(DIGITS - 1));
    assign frame_start = (cnt_q == '0) && (sel_q == '0);

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        sel_d = sel_q;
        if (slot_end) begin
            sel_d = frame_end ? '0 : sel_q + SEL_W'(1);
        end
    end

    // Decode from the next-state snapshot so the first slot of a frame already sees the fresh data.
    assign snap_dat_d = frame_start ? digit_data  : snap_dat_q;
    assign snap_dp_d  = frame_start ? dp_mask     : snap_dp_q;
    assign snap_lz_d  = frame_start ? lz_suppress : snap_lz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sel_q      <= '0;
            snap_dat_q <= '0;
            snap_dp_q  <= '0;
            snap_lz_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            snap_dat_q <= snap_dat_d;
            snap_dp_q  <= snap_dp_d;
            snap_lz_q  <= snap_lz_d;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FRM_W-1:0]  frm_q;
    logic              blink_ph_q;
    logic [DIGITS-1:0] snap_blk_q, snap_blk_d;

    assign snap_blk_d = frame_start ? blink_mask : snap_blk_q;
    assign blink_off  = blink_ph_q && snap_blk_d[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q      <= '0;
            blink_ph_q <= 1'b0;
            snap_blk_q <= '0;
        end else begin
            snap_blk_q <= snap_blk_d;
            if (frame_end) begin
                if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                    frm_q      <= '0;
                    blink_ph_q <= ~blink_ph_q;
                end else begin
                    frm_q <= frm_q + FRM_W'(1);
                end
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blink_off    = 1'b0;
`endif

    // A digit is a leading zero when it and every digit above it hold code 0; digit 0 always shows.
    always_comb begin
        zero_from_sel = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(sel_q) && snap_dat_d[4*j +: 4] != 4'd0) begin
                zero_from_sel = 1'b0;
            end
        end
        lz_off = snap_lz_d && (sel_q != '0) && zero_from_sel;
    end

    assign cur_code = snap_dat_d[{sel_q, 2'b00} +: 4];

    seg7_glyph_decode u_decode (
        .code_i  (cur_code),
        .dp_i    (snap_dp_d[sel_q]),
        .blank_i (lz_off || blink_off),
        .seg_o   (glyph_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (cnt_d < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;
    end

    always_comb begin
        seg_d = 8'h00;
        an_d  = '1;
        if (valid && state_q == ST_SHOW) begin
            seg_d        = glyph_seg;
            an_d[sel_q]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= 8'h00;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_start;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl at DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
module tb_seg7_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int RD     = 8;
    localparam int BC     = 2;
    localparam int BF     = 2;
    localparam int FRAME  = DIGITS * RD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [15:0] digit_data;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        lz_suppress;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string           name;
        logic [15:0]     dat;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][7:0] exp_seg;   // index = digit number
    } vec_t;

    vec_t        vecs [9];
    logic [12:0] sb [$];

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .digit_data  (digit_data),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {frame_tick, an, seg} for output position p of a frame (position 0 = tick cycle).
    function automatic logic [12:0] exp_word(input int p, input logic [3:0][7:0] segs);
        int         s  = p / RD;
        int         c  = p % RD;
        logic [3:0] a  = 4'b1111;
        logic [7:0] sg = 8'h00;
        if (c >= BC) begin
            a[s] = 1'b0;
            sg   = segs[s];
        end
        return {1'(p == 0), a, sg};
    endfunction

    task automatic wait_tick(input string name, input int exp_n);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        check({name, " tick gap"}, n, exp_n);
    endtask

    // Called on the negedge where frame_tick is high; checks all FRAME positions.
    task automatic compare_frame(input string name, input logic [3:0][7:0] segs,
                                 input int chg_p, input logic [15:0] chg_dat, input logic [3:0] chg_dp);
        for (int p = 0; p < FRAME; p++) sb.push_back(exp_word(p, segs));
        for (int p = 0; p < FRAME; p++) begin
            if (p > 0) @(negedge clk);
            check($sformatf("%s p%0d", name, p), {19'd0, frame_tick, an, seg}, {19'd0, sb.pop_front()});
            if (p == chg_p) begin
                digit_data = chg_dat;
                dp_mask    = chg_dp;
            end
        end
    endtask

    task automatic drive(input logic [15:0] dat, input logic [3:0] dp, input logic lz);
        digit_data  = dat;
        dp_mask     = dp;
        lz_suppress = lz;
    endtask

    initial begin
        vecs[0] = '{"scan",      16'h4321, 4'b0000, 1'b0, {8'h66, 8'hF2, 8'hDA, 8'h60}};
        vecs[1] = '{"lz_on",     16'h0070, 4'b0000, 1'b1, {8'h00, 8'h00, 8'hE0, 8'hFC}};
        vecs[2] = '{"lz_off",    16'h0070, 4'b0000, 1'b0, {8'hFC, 8'hFC, 8'hE0, 8'hFC}};
        vecs[3] = '{"glyphs",    16'hEBA5, 4'b1010, 1'b0, {8'h01, 8'h02, 8'h9F, 8'hB6}};
        vecs[4] = '{"lz_dp",     16'h0003, 4'b1111, 1'b1, {8'h00, 8'h00, 8'h00, 8'hF3}};
        vecs[5] = '{"lz_allz",   16'h0000, 4'b0001, 1'b1, {8'h00, 8'h00, 8'h00, 8'hFD}};
        vecs[6] = '{"lz_code12", 16'hC000, 4'b1000, 1'b1, {8'h01, 8'hFC, 8'hFC, 8'hFC}};
        vecs[7] = '{"digits",    16'h6890, 4'b0000, 1'b0, {8'hBE, 8'hFE, 8'hF6, 8'hFC}};
        vecs[8] = '{"lz_mid",    16'h0500, 4'b0001, 1'b1, {8'h00, 8'hB6, 8'hFC, 8'hFD}};

        rst_n      = 1'b0;
        valid      = 1'b1;
        blink_mask = 4'b0000;
        drive(vecs[0].dat, vecs[0].dp, vecs[0].lz);
        repeat (3) @(negedge clk);
        check("reset outputs", {19'd0, frame_tick, an, seg}, {19'd0, 1'b0, 4'b1111, 8'h00});
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].dat, vecs[i].dp, vecs[i].lz);
            wait_tick(vecs[i].name, 1);
            compare_frame(vecs[i].name, vecs[i].exp_seg, -1, 16'h0, 4'h0);
        end

        // Mid-frame input change must not show until the next snapshot
        drive(16'h4321, 4'b0000, 1'b0);
        wait_tick("snap_old", 1);
        compare_frame("snap_old", {8'h66, 8'hF2, 8'hDA, 8'h60}, 12, 16'h9999, 4'b1111);
        wait_tick("snap_new", 1);
        compare_frame("snap_new", {8'hF7, 8'hF7, 8'hF7, 8'hF7}, -1, 16'h0, 4'h0);

        // valid drop darkens on the next edge; counters keep running
        drive(16'h4321, 4'b0000, 1'b0);
        wait_tick("valid", 1);
        repeat (4) @(negedge clk);
        check("valid lit", {24'd0, an, seg}, {24'd0, 4'b1110, 8'h60});
        valid = 1'b0;
        @(negedge clk);
        check("valid dark", {24'd0, an, seg}, {24'd0, 4'b1111, 8'h00});
        valid = 1'b1;
        @(negedge clk);
        check("valid relit", {24'd0, an, seg}, {24'd0, 4'b1110, 8'h60});
        wait_tick("valid cont", 26);

        // Asynchronous reset in the middle of a lit slot, then blink sequence from a fresh start
        repeat (10) @(negedge clk);
        check("pre-reset lit", {28'd0, an}, {28'd0, 4'b1101});
        rst_n = 1'b0;
        #1;
        check("async reset", {19'd0, frame_tick, an, seg}, {19'd0, 1'b0, 4'b1111, 8'h00});
        blink_mask = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 6; f++) begin
            logic [7:0] d0;
            d0 = 8'h60;
`ifdef SEG7_BLINK_EN
            if (f == 2 || f == 3) d0 = 8'h00;
`endif
            wait_tick($sformatf("blink f%0d", f), 1);
            compare_frame($sformatf("blink f%0d", f), {8'h66, 8'hF2, 8'hDA, d0}, -1, 16'h0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
